// File: rtl/ledger_commit.sv
// Transfer commit controller: reads the sender and receiver words, checks funds and
// overflow, then writes back the debited sender and the credited receiver.
module ledger_commit #(
    parameter int ADDR_W = 5,
    parameter int VAL_W  = 8,
    parameter int TAG_W  = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        sender_id,
    input  logic [ADDR_W-1:0]        receiver_id,
    input  logic [VAL_W-1:0]         amount,
    input  logic                     verified,
    input  logic [TAG_W+VAL_W-1:0]   mem_rdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [TAG_W+VAL_W-1:0]   mem_wdata,
    output logic                     mem_we,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               status
);
    localparam int WORD_W = TAG_W + VAL_W;

    localparam logic [1:0] ST_OK         = 2'd0;
    localparam logic [1:0] ST_BAD_VERIFY = 2'd1;
    localparam logic [1:0] ST_NO_FUNDS   = 2'd2;
    localparam logic [1:0] ST_OVERFLOW   = 2'd3;

    typedef enum logic [2:0] {
        IDLE, CHECK, RD_SND, RD_RCV, EVAL, WR_SND, WR_RCV, FINISH
    } state_t;

    state_t state, next_state;

    logic [ADDR_W-1:0] snd_addr, rcv_addr;
    logic [VAL_W-1:0]  amt;
    logic [WORD_W-1:0] snd_word, rcv_word;
    logic [1:0]        next_status;

    logic [VAL_W-1:0]  snd_bal;
    logic [VAL_W-1:0]  rcv_bal_rd;
    logic [VAL_W:0]    rcv_sum_rd;
    logic              no_funds;
    logic              overflow;
    logic [WORD_W-1:0] snd_new;
    logic [WORD_W-1:0] rcv_new;

    // In EVAL the receiver word is still on mem_rdata, so decide from it directly.
    assign snd_bal    = snd_word[VAL_W-1:0];
    assign rcv_bal_rd = mem_rdata[VAL_W-1:0];
    assign rcv_sum_rd = {1'b0, rcv_bal_rd} + {1'b0, amt};
    assign no_funds   = (amt > snd_bal);
    assign overflow   = rcv_sum_rd[VAL_W];
    assign snd_new    = {snd_word[WORD_W-1:VAL_W], snd_bal - amt};
    assign rcv_new    = {rcv_word[WORD_W-1:VAL_W], rcv_word[VAL_W-1:0] + amt};

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= IDLE;
            status   <= ST_OK;
            snd_addr <= '0;
            rcv_addr <= '0;
            amt      <= '0;
            snd_word <= '0;
            rcv_word <= '0;
        end else begin
            state  <= next_state;
            status <= next_status;
            if (state == IDLE && start) begin
                snd_addr <= sender_id;
                rcv_addr <= receiver_id;
                amt      <= amount;
            end
            if (state == RD_RCV) snd_word <= mem_rdata;
            if (state == EVAL)   rcv_word <= mem_rdata;
        end
    end

    always_comb begin
        next_state  = state;
        next_status = status;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        busy        = (state != IDLE);
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = CHECK;
            end
            CHECK: begin
                if (!verified) begin
                    next_status = ST_BAD_VERIFY;
                    next_state  = FINISH;
                end else if (snd_addr == rcv_addr) begin
                    next_status = ST_OK;
                    next_state  = FINISH;
                end else begin
                    next_state = RD_SND;
                end
            end
            RD_SND: begin
                mem_addr   = snd_addr;
                next_state = RD_RCV;
            end
            RD_RCV: begin
                mem_addr   = rcv_addr;
                next_state = EVAL;
            end
            EVAL: begin
                if (no_funds) begin
                    next_status = ST_NO_FUNDS;
                    next_state  = FINISH;
                end else if (overflow) begin
                    next_status = ST_OVERFLOW;
                    next_state  = FINISH;
                end else begin
                    next_state = WR_SND;
                end
            end
            WR_SND: begin
                mem_we     = 1'b1;
                mem_addr   = snd_addr;
                mem_wdata  = snd_new;
                next_state = WR_RCV;
            end
            WR_RCV: begin
                mem_we      = 1'b1;
                mem_addr    = rcv_addr;
                mem_wdata   = rcv_new;
                next_status = ST_OK;
                next_state  = FINISH;
            end
            FINISH: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end
endmodule
